serial_rx_buf: RTL and testbench
================================

SERIAL_RX_BUF -- requirements
Module: serial_rx_buf

Interface
REQ-001 Parameter WIDTH, default 10, bits per received word (2..16).
REQ-002 Parameter DEPTH, default 4, output FIFO depth in words (power of 2, 2..16).
REQ-003 Parameter MSB_FIRST, default 1, bit order on the wire (1 = first bit lands in MSB).
REQ-004 Parameter TIMEOUT, default 255, clk cycles without a serial_clk rise before a partial word is discarded (0 = disabled).
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 enable  input  1  receiver enable.
REQ-008 serial_clk  input  1  asynchronous bit clock from microcontroller.
REQ-009 serial_data  input  1  asynchronous data from microcontroller, valid around serial_clk rise.
REQ-010 out_valid  output  1  FIFO holds at least one word.
REQ-011 out_data  output  WIDTH  head-of-FIFO word.
REQ-012 out_ready  input  1  consumer accepts head word.
REQ-013 level  output  clog2(DEPTH)+1  words currently stored.
REQ-014 overflow  output  1  sticky: a completed word was dropped.
REQ-015 frame_err  output  1  sticky: a partial word timed out.
REQ-016 clr_err  input  1  one-cycle clear of overflow and frame_err.

Function
REQ-017 serial_clk and serial_data SHALL each pass through a two-flop synchronizer plus one history flop; rise = sync2 & ~hist.
REQ-018 On rise, the synchronized data bit (sync2 of data) SHALL be shifted in; serial_clk rise to sample = 3 clk cycles.
REQ-019 MSB_FIRST=1: shift left, new bit into bit 0; MSB_FIRST=0: shift right, new bit into bit WIDTH-1.
REQ-020 FSM states: IDLE (bit_cnt=0) and RECV (0<bit_cnt<WIDTH).
REQ-021 IDLE -> RECV on rise with enable=1 (WIDTH>=2); RECV -> IDLE on the WIDTH-th rise, on timeout, or when enable=0.
REQ-022 On the WIDTH-th rise the completed word (including that bit) SHALL be pushed in the same cycle; bit_cnt returns to 0.
REQ-023 Timeout counter: cleared on every rise and in IDLE; increments each clk in RECV; on reaching TIMEOUT the partial word is discarded, state -> IDLE, frame_err set.
REQ-024 TIMEOUT=0: counter inactive, frame_err never sets.
REQ-025 enable=0: bit_cnt and timeout cleared, partial word discarded, rises ignored; synchronizers keep running; FIFO contents retained and drainable.
REQ-026 FIFO is show-ahead: out_valid = (level != 0); out_data = head word when valid, else 0.
REQ-027 Pop occurs when out_valid & out_ready; out_data and out_valid SHALL hold stable while out_valid & ~out_ready unless a pop occurs.
REQ-028 Push while full without a same-cycle pop: word dropped, contents unchanged, overflow set.
REQ-029 Push and pop in the same cycle while full: both performed, level unchanged, no overflow.
REQ-030 Push into an empty FIFO: out_valid rises the next cycle; the same word cannot be popped in the push cycle.
REQ-031 Read/write pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.
REQ-032 clr_err clears both sticky flags; a set event in the same cycle takes priority (flag remains 1).

Reset
REQ-033 While rst_n=0: synchronizers, shift register, bit_cnt, timeout counter, pointers and level = 0; state IDLE; out_valid=0, out_data=0, level=0, overflow=0, frame_err=0.
REQ-034 Reset assertion mid-word or with FIFO occupied SHALL discard all data; receiving resumes on the first rise after release.

Verification
REQ-035 WIDTH=10, MSB_FIRST=1, send 1011001110 with out_ready=0 -> out_valid=1 within 4 clk of the 10th rise, out_data=0x2CE, level=1.
REQ-036 MSB_FIRST=0, send same bit stream -> out_data=0x1CD.
REQ-037 DEPTH=4, out_ready=0, send 5 words -> level=4, overflow=1, first 4 words popped in order after out_ready=1; clr_err -> overflow=0.
REQ-038 FIFO full, out_ready=1 in the cycle of the 5th push -> no overflow, level stays 4, pop order preserved.
REQ-039 TIMEOUT=255, send 4 bits then idle 300 clk -> frame_err=1, level unchanged; next full 10-bit word is received correctly.
REQ-040 enable dropped after 6 bits, then raised, 10 bits sent -> exactly one word, equal to the 10 new bits; reset pulse with level=2 -> level=0, out_valid=0.

Source files
------------

// File: rtl/serial_rx_buf.sv
// Serial receiver: synchronizes an external bit clock and data line and assembles WIDTH-bit
// words. Completed words go into a show-ahead FIFO, with sticky overflow and timeout flags.
module serial_rx_buf #(
    parameter int WIDTH     = 10,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       serial_clk,
    input  logic                       serial_data,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       frame_err,
    input  logic                       clr_err
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = $clog2(WIDTH + 1);
    localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic {IDLE, RECV} state_t;

    state_t            state_q, state_d;
    logic              clk_s1, clk_s2, clk_h;
    logic              dat_s1, dat_s2;
    logic              rise;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d, word;
    logic              push, to_hit;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       level_q;
    logic              pop, full, wr_en, ovf_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b0;
            clk_s2 <= 1'b0;
            clk_h  <= 1'b0;
            dat_s1 <= 1'b0;
            dat_s2 <= 1'b0;
        end else begin
            clk_s1 <= serial_clk;
            clk_s2 <= clk_s1;
            clk_h  <= clk_s2;
            dat_s1 <= serial_data;
            dat_s2 <= dat_s1;
        end
    end

    assign rise = clk_s2 & ~clk_h;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            to_cnt_q  <= to_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        to_cnt_d  = to_cnt_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        to_hit    = 1'b0;
        if (MSB_FIRST != 0) word = {shreg_q[WIDTH-2:0], dat_s2};
        else                word = {dat_s2, shreg_q[WIDTH-1:1]};

        if (!enable) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            to_cnt_d  = '0;
            shreg_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    to_cnt_d = '0;
                    if (rise) begin
                        shreg_d   = word;
                        bit_cnt_d = CW'(1);
                        state_d   = RECV;
                    end
                end
                RECV: begin
                    if (rise) begin
                        to_cnt_d = '0;
                        // The final bit completes the word; push the shifted value directly.
                        if (bit_cnt_q == CW'(WIDTH - 1)) begin
                            push      = 1'b1;
                            shreg_d   = '0;
                            bit_cnt_d = '0;
                            state_d   = IDLE;
                        end else begin
                            shreg_d   = word;
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end else if (TIMEOUT != 0) begin
                        if (to_cnt_q == TW'(TO_LAST)) begin
                            to_hit    = 1'b1;
                            state_d   = IDLE;
                            bit_cnt_d = '0;
                            to_cnt_d  = '0;
                            shreg_d   = '0;
                        end else begin
                            to_cnt_d = to_cnt_q + TW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign out_valid = (level_q != '0);
    assign pop       = out_valid & out_ready;
    assign full      = (level_q == (AW + 1)'(DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_en     = push & (~full | pop);
    assign ovf_set   = push & full & ~pop;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign level     = level_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   level_q <= level_q + (AW + 1)'(1);
                2'b01:   level_q <= level_q - (AW + 1)'(1);
                default: level_q <= level_q;
            endcase
            overflow  <= ovf_set | (overflow & ~clr_err);
            frame_err <= to_hit | (frame_err & ~clr_err);
        end
    end

endmodule

// File: tb/tb_serial_rx_buf.sv
// Scoreboard bench for serial_rx_buf: words are sent bit by bit on serial_clk/serial_data,
// expected words are queued at send time and compared as the FIFO is drained.
module tb_serial_rx_buf;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       serial_clk = 1'b0;
    logic       serial_data = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr_err = 1'b0;
    logic       out_valid;
    logic [9:0] out_data;
    logic [2:0] level;
    logic       overflow;
    logic       frame_err;

    logic       lsb_ready = 1'b0;
    logic       lsb_valid;
    logic [9:0] lsb_data;
    logic [2:0] lsb_level;
    logic       lsb_overflow;
    logic       lsb_frame_err;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    serial_rx_buf #(.WIDTH(10), .DEPTH(4), .MSB_FIRST(1), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .serial_clk(serial_clk),
        .serial_data(serial_data), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .level(level), .overflow(overflow),
        .frame_err(frame_err), .clr_err(clr_err)
    );

    serial_rx_buf #(.WIDTH(10), .DEPTH(4), .MSB_FIRST(0), .TIMEOUT(255)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .enable(enable), .serial_clk(serial_clk),
        .serial_data(serial_data), .out_valid(lsb_valid), .out_data(lsb_data),
        .out_ready(lsb_ready), .level(lsb_level), .overflow(lsb_overflow),
        .frame_err(lsb_frame_err), .clr_err(clr_err)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic bit_rise(input logic b);
        serial_data = b;
        repeat (2) @(negedge clk);
        serial_clk = 1'b1;
    endtask

    task automatic bit_fall();
        serial_clk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bit_rise(b);
        repeat (4) @(negedge clk);
        bit_fall();
    endtask

    task automatic send_bits(input logic [9:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[9-i]);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && cyc < 100) begin
            if (out_valid) begin
                checks++;
                if (out_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL drain_data: got %h expected %h", out_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d words still expected, got none", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_extra: out_valid %b expected 0 after drain", out_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_data !== 10'h000) begin errors++; $display("FAIL reset_data: got %h expected 000", out_data); end
        checks++;
        if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++;
        if (overflow !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got ovf %b ferr %b expected 0 0", overflow, frame_err);
        end
        rst_n = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_bit_order();
        logic [9:0] w;
        int lat;
        w = 10'b1011001110;
        send_bits(w, 9);
        bit_rise(w[0]);
        lat = 0;
        for (int i = 1; i <= 4 && lat == 0; i++) begin
            @(negedge clk);
            if (out_valid) lat = i;
        end
        checks++;
        if (lat == 0) begin errors++; $display("FAIL first_latency: out_valid got 0 expected 1 within 4 clk"); end
        checks++;
        if (out_data !== 10'h2CE) begin errors++; $display("FAIL msb_data: got %h expected 2ce", out_data); end
        checks++;
        if (level !== 3'd1) begin errors++; $display("FAIL msb_level: got %0d expected 1", level); end
        checks++;
        if (lsb_data !== 10'h1CD) begin errors++; $display("FAIL lsb_data: got %h expected 1cd", lsb_data); end
        bit_fall();
        lsb_ready = 1'b1;
        exp_q.push_back(10'h2CE);
        drain();
    endtask

    task automatic test_overflow();
        logic [9:0] w;
        for (int i = 0; i < 5; i++) begin
            w = 10'($urandom);
            send_bits(w, 10);
            if (i < 4) exp_q.push_back(w);
        end
        checks++;
        if (level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d expected 4", level); end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        drain();
        pulse_clr();
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_full_pop();
        logic [9:0] w;
        for (int i = 0; i < 4; i++) begin
            w = 10'($urandom);
            send_bits(w, 10);
            exp_q.push_back(w);
        end
        checks++;
        if (level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d expected 4", level); end
        w = 10'($urandom);
        send_bits(w, 9);
        bit_rise(w[0]);
        repeat (2) @(negedge clk);
        checks++;
        if (out_data !== exp_q[0]) begin errors++; $display("FAIL full_head: got %h expected %h", out_data, exp_q[0]); end
        void'(exp_q.pop_front());
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_q.push_back(w);
        checks++;
        if (level !== 3'd4) begin errors++; $display("FAIL full_pop_level: got %0d expected 4", level); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL full_pop_ovf: got %b expected 0", overflow); end
        @(negedge clk);
        bit_fall();
        drain();
    endtask

    task automatic test_timeout();
        logic [9:0] w;
        w = 10'($urandom);
        send_bits(w, 4);
        repeat (300) @(negedge clk);
        checks++;
        if (frame_err !== 1'b1) begin errors++; $display("FAIL timeout_ferr: got %b expected 1", frame_err); end
        checks++;
        if (level !== 3'd0) begin errors++; $display("FAIL timeout_level: got %0d expected 0", level); end
        w = 10'($urandom);
        send_bits(w, 10);
        exp_q.push_back(w);
        drain();
        pulse_clr();
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b expected 0", frame_err); end
    endtask

    task automatic test_enable();
        logic [9:0] wa, wb;
        wa = 10'($urandom);
        wb = 10'($urandom);
        send_bits(wa, 6);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        send_bits(wa, 2);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        send_bits(wb, 10);
        exp_q.push_back(wb);
        checks++;
        if (level !== 3'd1) begin errors++; $display("FAIL enable_level: got %0d expected 1", level); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [9:0] w;
        for (int i = 0; i < 2; i++) begin
            w = 10'($urandom);
            send_bits(w, 10);
        end
        send_bits(w, 3);
        checks++;
        if (level !== 3'd2) begin errors++; $display("FAIL b2b_level: got %0d expected 2", level); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (level !== 3'd0 || out_valid !== 1'b0 || out_data !== 10'h000) begin
            errors++;
            $display("FAIL midreset: got level %0d valid %b data %h expected 0 0 000", level, out_valid, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        w = 10'($urandom);
        send_bits(w, 10);
        exp_q.push_back(w);
        drain();
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_overflow();
        test_full_pop();
        test_timeout();
        test_enable();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
